dp_ram_dma: RTL and testbench
=============================

// Module: dp_ram_dma
// PURPOSE
//  Word-copy/fill engine. Acts as the initiator for a two-port 32-bit synchronous
//  RAM with byte enables and 1-cycle registered read data. Port A reads the
//  source, port B writes the destination. Copy mode streams one word per cycle;
//  fill mode writes a constant. Sits beside the SoC data RAM and is started by
//  a CSR block.
// PARAMETERS
//  ADDR_WIDTH  8  RAM word-address width; all addresses wrap modulo 2**ADDR_WIDTH
// PORTS
//  clk          in   1           clock, all logic on posedge
//  rst_n        in   1           synchronous active-low reset
//  start_i      in   1           start request, sampled only in IDLE
//  fill_i       in   1           1 = fill mode, 0 = copy mode (latched at start)
//  src_addr_i   in   ADDR_WIDTH  source word address (latched at start)
//  dst_addr_i   in   ADDR_WIDTH  destination word address (latched at start)
//  len_i        in   ADDR_WIDTH+1 word count, 0..2**ADDR_WIDTH (latched)
//  fill_data_i  in   32          fill word (latched at start)
//  abort_i      in   1           stop issuing reads/writes, sampled in RUN
//  busy_o       out  1           transfer in progress
//  done_o       out  1           1-cycle completion pulse
//  count_o      out  ADDR_WIDTH+1 words written in current/last transfer
//  rd_en_o, rd_we_o(=0), rd_be_o(4, =4'hF), rd_addr_o(AW), rd_wdata_o(32, =0)  out  RAM port A
//  rd_rdata_i   in   32          RAM port A read data (valid cycle after rd_en_o)
//  wr_en_o, wr_we_o(=wr_en_o), wr_be_o(4, =4'hF), wr_addr_o(AW), wr_wdata_o(32)  out  RAM port B
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state IDLE; busy_o, done_o, rd_en_o, wr_en_o = 0;
//    count_o, addresses, latched data = 0. Reset mid-transfer aborts silently: no done_o.
//  - FSM: IDLE -> RUN (start_i, len>0, copy) | FILL (start_i, len>0, fill)
//    | DONE (start_i, len=0); RUN -> DRAIN after last/aborted read;
//    DRAIN -> DONE; FILL -> DONE after last/aborted write; DONE -> IDLE.
//  - Cycle numbering: start sampled at edge ending C0. All enables/addresses are registered.
//  - Copy: C1..C_len: rd_en_o=1, rd_addr_o=src+i-1 in Ci. C2..C_len+1: wr_en_o=1,
//    wr_addr_o=dst+i-2, wr_wdata_o=rd_rdata_i (combinational pass-through).
//    busy_o=1 in C1..C_len+1; done_o=1 in C_len+2.
//  - Fill: C1..C_len: wr_en_o=1, wr_addr_o=dst+i-1, wr_wdata_o=latched fill word;
//    no reads; busy_o in C1..C_len; done_o in C_len+1.
//  - len=0: no RAM access, busy_o stays 0, done_o=1 in C1.
//  - count_o cleared at start, +1 per write issued, held after done until next start.
//  - abort_i=1 sampled at end of Ck (copy RUN): no further reads; the read from Ck
//    is still written in Ck+1; done_o in Ck+2; count_o=k. In FILL: write in Ck
//    completes, none after; done_o in Ck+1. abort_i ignored outside RUN/FILL.
//  - start_i while not IDLE is ignored (no re-latch).
//  - Address arithmetic wraps modulo 2**ADDR_WIDTH; len=2**ADDR_WIDTH touches every word.
//  - Overlapping copy with src<dst<src+len is not supported; overlap contents
//    unspecified. dst<=src overlap copies correctly (forward order).
//  - wr_wdata_o is don't-care when wr_en_o=0.
// TESTING
//  1 Copy: RAM[0x10..0x13]=A0..A3, start src=0x10 dst=0x40 len=4 -> RAM[0x40..0x43]
//    =A0..A3, wr_en_o in C2..C5, done_o in C6, count_o=4.
//  2 Fill wrap: fill_i=1, dst=0xFE, len=3, data=0xDEADBEEF -> RAM[0xFE],[0xFF],[0x00]
//    =0xDEADBEEF, done_o in C4, no rd_en_o ever.
//  3 len=0 -> no rd_en_o/wr_en_o, busy_o=0, done_o=1 in C1, count_o=0.
//  4 Abort: copy len=8, abort_i at end of C2 -> 2 reads, 2 writes, done_o in C4,
//    count_o=2, RAM[dst+2..dst+7] unchanged.
//  5 start_i pulsed in C3 of a len=6 copy with different src -> ignored; original
//    transfer completes, done_o in C8.
//  6 rst_n=0 in C3 of len=8 copy -> next cycle all enables 0, busy_o=0, no done_o;
//    new start after reset copies correctly.

Source files
------------

// File: rtl/dp_ram_dma.sv
// Word copy/fill engine driving a two-port synchronous RAM: port A reads the
// source, port B writes the destination, one word per cycle.
module dp_ram_dma #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  fill_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic [31:0]           fill_data_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  rd_en_o,
  output logic                  rd_we_o,
  output logic [3:0]            rd_be_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [31:0]           rd_wdata_o,
  input  logic [31:0]           rd_rdata_i,
  output logic                  wr_en_o,
  output logic                  wr_we_o,
  output logic [3:0]            wr_be_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [31:0]           wr_wdata_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_FILL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;

  state_t                  state_q, state_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH:0]     rem_q, rem_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic                    fill_q, fill_d;
  logic [31:0]             fill_data_q, fill_data_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      rem_q       <= '0;
      count_q     <= '0;
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      rem_q       <= rem_d;
      count_q     <= count_d;
      fill_q      <= fill_d;
      fill_data_q <= fill_data_d;
    end
  end

  // rem_q counts accesses still to issue after the one currently presented.
  // The write pointer advances only after a write has been presented, so in
  // copy mode it sits on dst during the first (read-only) cycle.
  always_comb begin
    state_d     = state_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_en_q ? (wr_addr_q + ADDR_ONE) : wr_addr_q;
    rem_d       = rem_q;
    count_d     = count_q + {{ADDR_WIDTH{1'b0}}, wr_en_q};
    fill_d      = fill_q;
    fill_data_d = fill_data_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          count_d     = '0;
          fill_d      = fill_i;
          fill_data_d = fill_data_i;
          rd_addr_d   = src_addr_i;
          wr_addr_d   = dst_addr_i;
          if (len_i == '0) begin
            state_d = S_DONE;
          end else begin
            rem_d = len_i - LEN_ONE;
            if (fill_i) begin
              state_d = S_FILL;
              wr_en_d = 1'b1;
            end else begin
              state_d = S_RUN;
              rd_en_d = 1'b1;
            end
          end
        end
      end
      S_RUN: begin
        // Every RUN cycle carries a read whose data is written next cycle.
        wr_en_d = 1'b1;
        if (abort_i || rem_q == '0) begin
          state_d = S_DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_ONE;
          rem_d     = rem_q - LEN_ONE;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_FILL: begin
        if (abort_i || rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          wr_en_d = 1'b1;
          rem_d   = rem_q - LEN_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o     = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_FILL);
  assign done_o     = (state_q == S_DONE);
  assign count_o    = count_q;

  assign rd_en_o    = rd_en_q;
  assign rd_we_o    = 1'b0;
  assign rd_be_o    = 4'hF;
  assign rd_addr_o  = rd_addr_q;
  assign rd_wdata_o = 32'h0;

  // Copy data is forwarded straight from the RAM read port to avoid a bubble.
  assign wr_en_o    = wr_en_q;
  assign wr_we_o    = wr_en_q;
  assign wr_be_o    = 4'hF;
  assign wr_addr_o  = wr_addr_q;
  assign wr_wdata_o = fill_q ? fill_data_q : rd_rdata_i;

endmodule

// File: tb/tb_dp_ram_dma.sv
// Directed bench for dp_ram_dma: a RAM model, expected-event queues filled by
// the stimulus, and a negedge monitor that pops and compares each event.
module tb_dp_ram_dma;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          fill_i;
  logic [AW-1:0] src_addr_i;
  logic [AW-1:0] dst_addr_i;
  logic [AW:0]   len_i;
  logic [31:0]   fill_data_i;
  logic          abort_i;
  logic          busy_o;
  logic          done_o;
  logic [AW:0]   count_o;
  logic          rd_en_o;
  logic          rd_we_o;
  logic [3:0]    rd_be_o;
  logic [AW-1:0] rd_addr_o;
  logic [31:0]   rd_wdata_o;
  logic [31:0]   rd_rdata_i;
  logic          wr_en_o;
  logic          wr_we_o;
  logic [3:0]    wr_be_o;
  logic [AW-1:0] wr_addr_o;
  logic [31:0]   wr_wdata_o;

  dp_ram_dma #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .fill_i(fill_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .fill_data_i(fill_data_i), .abort_i(abort_i), .busy_o(busy_o),
    .done_o(done_o), .count_o(count_o), .rd_en_o(rd_en_o), .rd_we_o(rd_we_o),
    .rd_be_o(rd_be_o), .rd_addr_o(rd_addr_o), .rd_wdata_o(rd_wdata_o),
    .rd_rdata_i(rd_rdata_i), .wr_en_o(wr_en_o), .wr_we_o(wr_we_o),
    .wr_be_o(wr_be_o), .wr_addr_o(wr_addr_o), .wr_wdata_o(wr_wdata_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read on port A, byte-enabled write on port B.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (rd_en_o) rd_rdata_i <= mem[rd_addr_o];
    if (wr_en_o && wr_we_o) begin
      for (int b = 0; b < 4; b++)
        if (wr_be_o[b]) mem[wr_addr_o][8*b +: 8] <= wr_wdata_o[8*b +: 8];
    end
  end

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  ev_t done_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk(input int c, input logic [7:0] a, input logic [31:0] d);
    ev_t e;
    e.cyc = c; e.addr = a; e.data = d;
    return e;
  endfunction

  // Monitor: every observed RAM access or done pulse must match the head of its queue.
  always @(negedge clk) begin
    ev_t e;
    if (rd_en_o === 1'b1) begin
      $display("[%0d] read  addr=%h", cyc, rd_addr_o);
      if (rd_q.size() == 0) chk("rd_unexpected", {24'h0, rd_addr_o}, 32'hFFFF_FFFF);
      else begin
        e = rd_q.pop_front();
        chk("rd_cycle", cyc, e.cyc);
        chk("rd_addr", {24'h0, rd_addr_o}, {24'h0, e.addr});
      end
    end
    if (wr_en_o === 1'b1) begin
      $display("[%0d] write addr=%h data=%h", cyc, wr_addr_o, wr_wdata_o);
      if (wr_q.size() == 0) chk("wr_unexpected", {24'h0, wr_addr_o}, 32'hFFFF_FFFF);
      else begin
        e = wr_q.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_addr", {24'h0, wr_addr_o}, {24'h0, e.addr});
        chk("wr_data", wr_wdata_o, e.data);
        chk("wr_we", {31'h0, wr_we_o}, 32'h1);
      end
    end
    if (done_o === 1'b1) begin
      $display("[%0d] done  count=%0d", cyc, count_o);
      if (done_q.size() == 0) chk("done_unexpected", {23'h0, count_o}, 32'hFFFF_FFFF);
      else begin
        e = done_q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_count", {23'h0, count_o}, e.data);
      end
    end
  end

  task automatic launch(input logic f, input logic [7:0] s, input logic [7:0] d,
                        input logic [8:0] l, input logic [31:0] fd, output int c0);
    fill_i = f; src_addr_i = s; dst_addr_i = d; len_i = l; fill_data_i = fd;
    start_i = 1'b1;
    c0 = cyc;
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drained(input string nm);
    chk({nm, "_rd_left"}, rd_q.size(), 0);
    chk({nm, "_wr_left"}, wr_q.size(), 0);
    chk({nm, "_done_left"}, done_q.size(), 0);
    rd_q.delete(); wr_q.delete(); done_q.delete();
  endtask

  function automatic logic [31:0] init_word(input int a);
    return 32'h5000_0000 | 32'(a);
  endfunction

  initial begin
    int c0;
    for (int a = 0; a < 256; a++) mem[a] = init_word(a);
    rst_n = 1'b0; start_i = 1'b0; fill_i = 1'b0; src_addr_i = '0; dst_addr_i = '0;
    len_i = '0; fill_data_i = '0; abort_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    chk("rst_rd_en", {31'h0, rd_en_o}, 32'h0);
    chk("rst_wr_en", {31'h0, wr_en_o}, 32'h0);
    chk("rst_count", {23'h0, count_o}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: copy 4 words 0x10 -> 0x40
    for (int i = 0; i < 4; i++) mem[8'h10 + i] = 32'hA0 + 32'(i);
    launch(1'b0, 8'h10, 8'h40, 9'd4, 32'h0, c0);
    for (int i = 1; i <= 4; i++) rd_q.push_back(mk(c0 + i, 8'(8'h10 + i - 1), 32'h0));
    for (int i = 2; i <= 5; i++) wr_q.push_back(mk(c0 + i, 8'(8'h40 + i - 2), 32'hA0 + 32'(i - 2)));
    done_q.push_back(mk(c0 + 6, 8'h0, 32'd4));
    wait_cycle(c0 + 1); start_i = 1'b0;
    wait_cycle(c0 + 8);
    drained("t1");
    for (int i = 0; i < 4; i++) chk("t1_mem", mem[8'h40 + i], 32'hA0 + 32'(i));

    // 2: fill 3 words at 0xFE, wrapping to 0x00
    launch(1'b1, 8'h00, 8'hFE, 9'd3, 32'hDEAD_BEEF, c0);
    for (int i = 1; i <= 3; i++) wr_q.push_back(mk(c0 + i, 8'(8'hFE + i - 1), 32'hDEAD_BEEF));
    done_q.push_back(mk(c0 + 4, 8'h0, 32'd3));
    wait_cycle(c0 + 1); start_i = 1'b0;
    wait_cycle(c0 + 6);
    drained("t2");
    chk("t2_mem_fe", mem[8'hFE], 32'hDEAD_BEEF);
    chk("t2_mem_ff", mem[8'hFF], 32'hDEAD_BEEF);
    chk("t2_mem_00", mem[8'h00], 32'hDEAD_BEEF);

    // 3: zero length
    launch(1'b0, 8'h05, 8'h06, 9'd0, 32'h0, c0);
    done_q.push_back(mk(c0 + 1, 8'h0, 32'd0));
    wait_cycle(c0 + 1); start_i = 1'b0;
    chk("t3_busy", {31'h0, busy_o}, 32'h0);
    wait_cycle(c0 + 4);
    drained("t3");

    // 4: abort at end of C2 of an 8-word copy
    launch(1'b0, 8'h20, 8'h60, 9'd8, 32'h0, c0);
    rd_q.push_back(mk(c0 + 1, 8'h20, 32'h0));
    rd_q.push_back(mk(c0 + 2, 8'h21, 32'h0));
    wr_q.push_back(mk(c0 + 2, 8'h60, init_word(8'h20)));
    wr_q.push_back(mk(c0 + 3, 8'h61, init_word(8'h21)));
    done_q.push_back(mk(c0 + 4, 8'h0, 32'd2));
    wait_cycle(c0 + 1); start_i = 1'b0;
    wait_cycle(c0 + 2); abort_i = 1'b1;
    wait_cycle(c0 + 3); abort_i = 1'b0;
    wait_cycle(c0 + 7);
    drained("t4");
    for (int a = 8'h62; a <= 8'h67; a++) chk("t4_mem_untouched", mem[a], init_word(a));

    // 5: second start mid-transfer is ignored
    launch(1'b0, 8'h30, 8'h70, 9'd6, 32'h0, c0);
    for (int i = 1; i <= 6; i++) rd_q.push_back(mk(c0 + i, 8'(8'h30 + i - 1), 32'h0));
    for (int i = 2; i <= 7; i++) wr_q.push_back(mk(c0 + i, 8'(8'h70 + i - 2), init_word(8'h30 + i - 2)));
    done_q.push_back(mk(c0 + 8, 8'h0, 32'd6));
    wait_cycle(c0 + 1); start_i = 1'b0;
    wait_cycle(c0 + 3);
    src_addr_i = 8'h00; dst_addr_i = 8'h00; len_i = 9'd2; start_i = 1'b1;
    wait_cycle(c0 + 4); start_i = 1'b0;
    wait_cycle(c0 + 11);
    drained("t5");
    chk("t5_mem_75", mem[8'h75], init_word(8'h35));

    // 6: reset in C3 of an 8-word copy, then a fresh copy
    launch(1'b0, 8'h80, 8'h90, 9'd8, 32'h0, c0);
    for (int i = 1; i <= 3; i++) rd_q.push_back(mk(c0 + i, 8'(8'h80 + i - 1), 32'h0));
    wr_q.push_back(mk(c0 + 2, 8'h90, init_word(8'h80)));
    wr_q.push_back(mk(c0 + 3, 8'h91, init_word(8'h81)));
    wait_cycle(c0 + 1); start_i = 1'b0;
    wait_cycle(c0 + 3); rst_n = 1'b0;
    wait_cycle(c0 + 4);
    chk("t6_busy", {31'h0, busy_o}, 32'h0);
    chk("t6_rd_en", {31'h0, rd_en_o}, 32'h0);
    chk("t6_wr_en", {31'h0, wr_en_o}, 32'h0);
    chk("t6_count", {23'h0, count_o}, 32'h0);
    rst_n = 1'b1;
    wait_cycle(c0 + 12);
    drained("t6a");
    launch(1'b0, 8'h80, 8'hA0, 9'd3, 32'h0, c0);
    for (int i = 1; i <= 3; i++) rd_q.push_back(mk(c0 + i, 8'(8'h80 + i - 1), 32'h0));
    for (int i = 2; i <= 4; i++) wr_q.push_back(mk(c0 + i, 8'(8'hA0 + i - 2), init_word(8'h80 + i - 2)));
    done_q.push_back(mk(c0 + 5, 8'h0, 32'd3));
    wait_cycle(c0 + 1); start_i = 1'b0;
    wait_cycle(c0 + 7);
    drained("t6b");
    chk("t6_mem_a2", mem[8'hA2], init_word(8'h82));
    chk("t6_mem_92", mem[8'h92], init_word(8'h92));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
